// File: rtl/restoring_divider.sv
// Purpose : sequential unsigned restoring divider, DQ = A / B and DR = A % B, one quotient bit per clock.
// Latency : Start sampled at edge E0 -> Done pulse with valid DQ/DR after edge E0+WIDTH.
// Backpr. : none; Start is ignored while busy (no queuing), DQ/DR hold until the next completion.
//
// Ports:
//   Clk    - system clock, rising edge
//   Reset  - asynchronous active-low reset
//   A, B   - dividend / divisor, sampled together with Start
//   Start  - request, accepted only in IDLE
//   DQ, DR - registered quotient / remainder
//   Done   - registered one-cycle completion pulse
module restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Start,
    output logic [WIDTH-1:0] DQ,
    output logic [WIDTH-1:0] DR,
    output logic             Done
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;      // partial remainder; always < divisor, so WIDTH bits suffice
    logic [WIDTH-1:0] dvd;      // dividend shifts out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dsr;      // latched divisor
    logic [CW-1:0]    cnt;      // iterations completed

    // One iteration: shifted/trial are WIDTH+1 bits so the subtraction cannot overflow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;

    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
        q_bit   = ~trial[WIDTH];
        // When the trial goes negative, shifted < divisor, so its top bit is zero
        // and the restored remainder still fits in WIDTH bits.
        rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        dvd_nxt = (dvd << 1) | WIDTH'(q_bit);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            rem   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            DQ    <= '0;
            DR    <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        rem   <= '0;
                        dvd   <= A;
                        dsr   <= B;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        DQ    <= dvd_nxt;
                        DR    <= rem_nxt;
                        Done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// Purpose : randomized scoreboard bench for restoring_divider against a plain-arithmetic model.
// Latency : expects Done exactly 8 edges after the accepting edge.
// Backpr. : requests issued while the model says the divider is busy are expected to be dropped.
module tb_restoring_divider;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Start = 1'b0;
    logic [7:0] DQ;
    logic [7:0] DR;
    logic       Done;

    restoring_divider #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Start(Start),
        .DQ(DQ), .DR(DR), .Done(Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        int         edge_n;
    } exp_t;

    exp_t       sb[$];
    int         edge_cnt = 0;
    int         busy_end = -100;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] hold_q = '0;
    logic [7:0] hold_r = '0;

    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain unsigned division; divide by zero gives all ones and the dividend.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int e);
        exp_t x;
        if (b == 8'd0) begin
            x.q = 8'hFF;
            x.r = a;
        end else begin
            x.q = a / b;
            x.r = a % b;
        end
        x.edge_n = e + 8;
        return x;
    endfunction

    // Monitor: pops on every Done, otherwise checks that outputs hold their last value.
    always @(negedge Clk) begin
        exp_t e;
        if (!Reset) begin
            sb.delete();
            hold_q = '0;
            hold_r = '0;
        end
        if (Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got Done=1 DQ=%0d DR=%0d, expected no Done", DQ, DR);
            end else begin
                e = sb.pop_front();
                check("done_edge", edge_cnt, e.edge_n);
                check("dq", DQ, e.q);
                check("dr", DR, e.r);
                hold_q = e.q;
                hold_r = e.r;
            end
        end else begin
            check("dq_hold", DQ, hold_q);
            check("dr_hold", DR, hold_r);
            if (sb.size() > 0 && edge_cnt > sb[0].edge_n) begin
                e = sb.pop_front();
                check("missed_done_edge", edge_cnt, e.edge_n);
            end
        end
    end

    task automatic wait_idle();
        while (edge_cnt < busy_end) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Drive one request; the model decides whether the DUT should accept it.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        int e;
        @(negedge Clk);
        A = a;
        B = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        e = edge_cnt;
        if (e > busy_end && Reset) begin
            sb.push_back(model(a, b, e));
            busy_end = e + 8;
        end
        A = 8'($urandom);
        B = 8'($urandom);
    endtask

    initial begin
        int mode;
        logic [7:0] ra;
        logic [7:0] rb;

        // Reset held for several cycles
        repeat (5) @(negedge Clk);
        check("rst_dq", DQ, 0);
        check("rst_dr", DR, 0);
        check("rst_done", Done, 0);
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;

        // Basic division
        issue(8'd50, 8'd3);
        wait_idle();
        repeat (2) @(posedge Clk);
        #1;

        // Start while busy: the second request must be dropped
        issue(8'd50, 8'd3);
        @(posedge Clk);
        #1;
        issue(8'd200, 8'd7);
        wait_idle();
        repeat (2) @(posedge Clk);
        #1;

        // Boundary values, back-to-back
        wait_idle(); issue(8'd255, 8'd1);
        wait_idle(); issue(8'd7,   8'd9);
        wait_idle(); issue(8'd0,   8'd5);
        wait_idle(); issue(8'd255, 8'd255);

        // Divide by zero then a back-to-back request on the Done cycle
        wait_idle(); issue(8'd100, 8'd0);
        wait_idle(); issue(8'd99,  8'd10);
        wait_idle();
        repeat (2) @(posedge Clk);
        #1;

        // Abort mid-operation
        issue(8'd50, 8'd3);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b0;
        busy_end = -100;
        #1;
        check("abort_dq", DQ, 0);
        check("abort_dr", DR, 0);
        check("abort_done", Done, 0);
        repeat (12) @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        issue(8'd50, 8'd3);
        wait_idle();

        // Random traffic, mixing back-to-back, gaps and requests while busy
        for (int i = 0; i < 60; i++) begin
            mode = $urandom_range(0, 3);
            ra = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 8'd0;
                1:       rb = 8'($urandom_range(1, 15));
                default: rb = 8'($urandom);
            endcase
            if (mode != 0) begin
                wait_idle();
                repeat (mode - 1) @(posedge Clk);
                #1;
            end
            issue(ra, rb);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 30 && sb.size() > 0; k++) @(posedge Clk);
        repeat (2) @(posedge Clk);
        check("queue_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
